// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer and its UART frame formatter.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        SEND = 2'd2
    } fsm_state_t;

    localparam int unsigned FRAME_LEN      = 13;
    localparam int unsigned FRAME_LEN_DONE = 18;
    localparam int unsigned IDX_W          = 5;

    localparam logic [7:0] ASC_0 = 8'h30;
    localparam logic [7:0] COLON = 8'h3A;
    localparam logic [7:0] DOT   = 8'h2E;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] ASC_D = 8'h44;
    localparam logic [7:0] ASC_O = 8'h4F;
    localparam logic [7:0] ASC_N = 8'h4E;
    localparam logic [7:0] ASC_E = 8'h45;

    // Frozen copy of the timer inputs that a frame is rendered from.
    typedef struct packed {
        logic [5:0] hours;
        logic [5:0] minutes;
        logic [5:0] seconds;
        logic [6:0] centis;
        logic       done;
    } snap_t;

    function automatic logic [7:0] bcd_ascii(input logic [3:0] digit);
        return ASC_0 + {4'h0, digit};
    endfunction

endpackage

// File: rtl/timer_uart_formatter_bin2dec99.sv
// 7-bit binary to two BCD digits; anything above 99 reads as 99.
module bin2dec99 (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [6:0] clamped;

    always_comb begin
        clamped = (bin > 7'd99) ? 7'd99 : bin;
        tens    = 4'(clamped / 7'd10);
        ones    = 4'(clamped % 7'd10);
    end

endmodule

// File: rtl/timer_uart_formatter.sv
// Snapshots the timer and streams "HH:MM:SS.cc[ DONE]\r\n" over a valid/ready byte link.
module timer_uart_formatter
    import timer_pkg::*;
#(
    parameter int unsigned AUTO_PERIOD = 100,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic [6:0] centis,
    input  logic       done,
    input  logic       send,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy
);

    localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_PERIOD - 1);
    localparam logic [IDX_W-1:0] LAST_NORM = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_DONE = IDX_W'(FRAME_LEN_DONE - 1);

    fsm_state_t       state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    snap_t            snap_q, snap_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;

    logic             auto_tick;
    logic             req;
    logic             xfer;
    logic [IDX_W-1:0] last_idx;
    logic [3:0]       h1, h0, m1, m0, s1, s0, c1, c0;

    // Digits come from the next snapshot so the first byte is registered on SNAP exit.
    bin2dec99 u_hours   (.bin({1'b0, snap_d.hours}),   .tens(h1), .ones(h0));
    bin2dec99 u_minutes (.bin({1'b0, snap_d.minutes}), .tens(m1), .ones(m0));
    bin2dec99 u_seconds (.bin({1'b0, snap_d.seconds}), .tens(s1), .ones(s0));
    bin2dec99 u_centis  (.bin(snap_d.centis),          .tens(c1), .ones(c0));

    // Free-running auto-request counter; period 0 disables it.
    always_comb begin
        auto_tick = 1'b0;
        cnt_d     = '0;
        if (AUTO_PERIOD != 0) begin
            auto_tick = (cnt_q == AUTO_LAST);
            cnt_d     = auto_tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        pending_d = pending_q;
        snap_d    = snap_q;
        done_d    = done;
        tx_data_d = 8'h00;

        req      = send | auto_tick | (done & ~done_q);
        xfer     = tx_valid_q & tx_ready;
        last_idx = snap_q.done ? LAST_DONE : LAST_NORM;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SNAP;
                end
            end
            SNAP: begin
                snap_d  = '{hours: hours, minutes: minutes, seconds: seconds,
                            centis: centis, done: done};
                index_d = '0;
                state_d = SEND;
            end
            SEND: begin
                if (xfer) begin
                    if (index_q == last_idx) begin
                        index_d = '0;
                        state_d = (pending_q | req) ? SNAP : IDLE;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Entering SNAP consumes the pending request; anything else while busy queues one.
        if (state_d == SNAP) begin
            pending_d = 1'b0;
        end else if (req && state_q != IDLE) begin
            pending_d = 1'b1;
        end

        tx_valid_d = (state_d == SEND);
        busy_d     = (state_d != IDLE);

        if (tx_valid_d) begin
            case (index_d)
                5'd0:    tx_data_d = bcd_ascii(h1);
                5'd1:    tx_data_d = bcd_ascii(h0);
                5'd2:    tx_data_d = COLON;
                5'd3:    tx_data_d = bcd_ascii(m1);
                5'd4:    tx_data_d = bcd_ascii(m0);
                5'd5:    tx_data_d = COLON;
                5'd6:    tx_data_d = bcd_ascii(s1);
                5'd7:    tx_data_d = bcd_ascii(s0);
                5'd8:    tx_data_d = DOT;
                5'd9:    tx_data_d = bcd_ascii(c1);
                5'd10:   tx_data_d = bcd_ascii(c0);
                5'd11:   tx_data_d = snap_d.done ? SPACE : CR;
                5'd12:   tx_data_d = snap_d.done ? ASC_D : LF;
                5'd13:   tx_data_d = ASC_O;
                5'd14:   tx_data_d = ASC_N;
                5'd15:   tx_data_d = ASC_E;
                5'd16:   tx_data_d = CR;
                5'd17:   tx_data_d = LF;
                default: tx_data_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            index_q    <= '0;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            snap_q     <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            snap_q     <= snap_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_timer_uart_formatter.sv
// Scoreboard bench: expected frames are rendered from time values with $sformatf and queued per byte.
module tb_timer_uart_formatter;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reset2 = 1'b1;
    logic [5:0] hours = '0, minutes = '0, seconds = '0;
    logic [6:0] centis = '0;
    logic       done = 1'b0, send = 1'b0, tx_ready = 1'b1;
    logic       tx_ready2 = 1'b1;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2, busy, busy2;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         acc_cnt = 0;
    bit         bp_en = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    longint     cyc = 0;

    bit         auto_on = 1'b0;
    int         auto_idx = 0;
    longint     last_start = -1;
    int         starts = 0;
    logic       prev_v2 = 1'b0;
    byte_q_t    auto_exp;

    always #5 clk = ~clk;

    timer_uart_formatter #(.AUTO_PERIOD(0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .hours(hours), .minutes(minutes), .seconds(seconds),
        .centis(centis), .done(done), .send(send), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy)
    );

    timer_uart_formatter #(.AUTO_PERIOD(50), .CNT_W(16)) dut_auto (
        .clk(clk), .reset(reset2), .hours(hours), .minutes(minutes), .seconds(seconds),
        .centis(centis), .done(done), .send(1'b0), .tx_ready(tx_ready2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .busy(busy2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic byte_q_t make_frame(input int h, input int m, input int s,
                                           input int c, input bit d);
        byte_q_t q;
        string   str;
        int      cc;
        cc  = (c > 99) ? 99 : c;
        str = $sformatf("%02d:%02d:%02d.%02d", h, m, s, cc);
        if (d) str = {str, " DONE"};
        for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    // Random backpressure, driven just after the active edge.
    initial forever begin
        @(posedge clk);
        #1;
        tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Byte monitor for the main instance.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!tx_valid || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable got valid=%0b data=%02h required valid=1 data=%02h",
                             tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte got=%02h required=none", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL frame_byte got=%02h required=%02h", tx_data, e);
                    end
                end
                acc_cnt++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    // Monitor for the auto-period instance: frame spacing and content.
    always @(negedge clk) begin
        if (auto_on && !reset2) begin
            if (tx_valid2 && !prev_v2) begin
                if (last_start >= 0) begin
                    checks++;
                    if (cyc - last_start != 50) begin
                        errors++;
                        $display("FAIL auto_period got=%0d required=50", cyc - last_start);
                    end
                end
                last_start = cyc;
                starts++;
                auto_idx = 0;
            end
            if (tx_valid2) begin
                checks++;
                if (auto_idx >= auto_exp.size()) begin
                    errors++;
                    $display("FAIL auto_byte got=%02h required=none idx=%0d", tx_data2, auto_idx);
                end else if (tx_data2 !== auto_exp[auto_idx]) begin
                    errors++;
                    $display("FAIL auto_byte got=%02h required=%02h idx=%0d",
                             tx_data2, auto_exp[auto_idx], auto_idx);
                end
                auto_idx++;
            end
        end
        prev_v2 = tx_valid2;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_time(input int h, input int m, input int s, input int c);
        hours   = 6'(h);
        minutes = 6'(m);
        seconds = 6'(s);
        centis  = 7'(c);
    endtask

    task automatic expect_frame(input int h, input int m, input int s, input int c, input bit d);
        byte_q_t f;
        f = make_frame(h, m, s, c, d);
        foreach (f[i]) exp_q.push_back(f[i]);
    endtask

    task automatic pulse_send();
        send = 1'b1;
        step();
        send = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 2000 && !(exp_q.size() == 0 && !busy)) begin
            step();
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s_timeout got left=%0d required left=0", name, exp_q.size());
        end
    endtask

    task automatic wait_acc(input int target, input string name);
        int n = 0;
        while (n < 500 && acc_cnt < target) begin
            step();
            n++;
        end
        checks++;
        if (acc_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout got=%0d required=%0d", name, acc_cnt, target);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // Reset state
        repeat (3) step();
        chk("reset_tx_valid", 32'(tx_valid), 32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'h00);
        chk("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (3) step();

        // Basic frame and latency
        set_time(1, 2, 3, 4);
        expect_frame(1, 2, 3, 4, 0);
        send = 1'b1;
        step();
        send = 1'b0;
        chk("snap_cycle_valid", 32'(tx_valid), 32'd0);
        chk("snap_cycle_busy", 32'(busy), 32'd1);
        step();
        chk("latency_valid", 32'(tx_valid), 32'd1);
        chk("first_byte", 32'(tx_data), 32'h30);
        wait_idle("basic");
        repeat (5) step();
        chk("idle_after_valid", 32'(tx_valid), 32'd0);
        chk("idle_after_busy", 32'(busy), 32'd0);

        // Backpressure
        bp_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_time(0, 59, 59, 99);
            expect_frame(0, 59, 59, 99, 0);
            pulse_send();
            wait_idle("backpressure");
        end
        bp_en = 1'b0;
        step();

        // Done rising edge with no send
        set_time(0, 0, 0, 0);
        base = acc_cnt;
        expect_frame(0, 0, 0, 0, 1);
        done = 1'b1;
        step();
        wait_idle("done_edge");
        chk("done_frame_len", 32'(acc_cnt - base), 32'd18);

        // Inputs change mid-frame plus coalesced sends
        done = 1'b0;
        repeat (3) step();
        set_time(5, 6, 7, 8);
        expect_frame(5, 6, 7, 8, 0);
        expect_frame(10, 20, 30, 40, 0);
        base = acc_cnt;
        pulse_send();
        wait_acc(base + 3, "midframe");
        set_time(10, 20, 30, 40);
        pulse_send();
        step();
        pulse_send();
        step();
        pulse_send();
        wait_idle("midframe");
        repeat (20) step();
        chk("coalesce_bytes", 32'(acc_cnt - base), 32'd26);
        chk("coalesce_busy", 32'(busy), 32'd0);

        // Randomized frames under backpressure
        bp_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int h, m, s, c;
            bit d;
            h = $urandom_range(0, 23);
            m = $urandom_range(0, 59);
            s = $urandom_range(0, 59);
            c = $urandom_range(0, 127);
            d = 1'($urandom_range(0, 1));
            set_time(h, m, s, c);
            expect_frame(h, m, s, c, d);
            if (d && !done) begin
                done = 1'b1;
                step();
            end else begin
                done = d;
                pulse_send();
            end
            wait_idle("random");
        end
        bp_en = 1'b0;
        done = 1'b0;
        repeat (3) step();

        // Reset in the middle of a frame
        set_time(1, 1, 1, 1);
        expect_frame(1, 1, 1, 1, 0);
        base = acc_cnt;
        pulse_send();
        wait_acc(base + 5, "reset_mid");
        chk("pre_reset_valid", 32'(tx_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_drop_valid", 32'(tx_valid), 32'd0);
        chk("reset_drop_busy", 32'(busy), 32'd0);
        exp_q.delete();
        base = acc_cnt;
        repeat (2) step();
        reset = 1'b0;
        repeat (30) step();
        chk("no_resume_valid", 32'(tx_valid), 32'd0);
        chk("no_resume_busy", 32'(busy), 32'd0);
        chk("no_resume_bytes", 32'(acc_cnt - base), 32'd0);

        // Auto-period instance with clamped centiseconds
        set_time(12, 34, 56, 120);
        auto_exp = make_frame(12, 34, 56, 120, 0);
        step();
        reset2  = 1'b0;
        auto_on = 1'b1;
        repeat (230) step();
        auto_on = 1'b0;
        reset2  = 1'b1;
        chk("auto_starts", 32'(starts), 32'd4);
        chk("auto_no_main_bytes", 32'(exp_q.size()), 32'd0);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
